cpu_bus_cmd_fifo: RTL and testbench
===================================

Name: cpu_bus_cmd_fifo

Overview:
- Upstream front-end of the VGA command processor.
- Samples the asynchronous 6502 bus (CLK_CPU, EN, RW, REG, DATA) inside the CLK_FAST domain and detects completed CPU write cycles to the video chip.
- Queues each completed write as an 11-bit {REG, DATA} command in a FIFO.
- The command state machine drains the FIFO with a valid/ready handshake, so no logic runs on CLK_CPU edges.

Parameters:
- DEPTH_LOG2, 4: FIFO depth = 2^DEPTH_LOG2 entries.
- SYNC_STAGES, 2: synchronizer flop stages for the bus inputs; minimum 2.

Ports:
- CLK_FAST  input  1  system clock; all logic on its rising edge.
- RESET  input  1  asynchronous, active-high reset.
- CLK_CPU  input  1  6502 phi2, asynchronous to CLK_FAST.
- EN  input  1  chip select, active low.
- RW  input  1  1 = CPU read, 0 = CPU write.
- REG  input  3  register select.
- DATA  input  8  CPU data bus.
- cmd_valid  output  1  FIFO head holds a command.
- cmd_reg  output  3  head command register field.
- cmd_data  output  8  head command data field.
- cmd_ready  input  1  consumer accepts the head this cycle.
- fifo_count  output  DEPTH_LOG2+1  number of stored entries.
- overflow  output  1  sticky: a write was dropped because the FIFO was full.
- clr_overflow  input  1  clears overflow.

Behaviour:
- Clock and reset: one clock, CLK_FAST. RESET is asynchronous and active-high.
- Reset values:
  - Synchronizer chains: phi2 = 0, en_n = 1, rw = 1, REG/DATA = 0.
  - phi2_d = 0, write_seen = 0, capture register = 0.
  - Read and write pointers = 0, fifo_count = 0, cmd_valid = 0, overflow = 0.
  - cmd_reg/cmd_data = contents of entry 0; don't-care while cmd_valid = 0.
- Synchronization:
  - CLK_CPU, EN and RW each pass through SYNC_STAGES flops, giving phi2_s, en_n_s, rw_s.
  - REG and DATA pass through the same number of flops so they stay cycle-aligned with the control signals.
  - phi2_d is phi2_s delayed by one cycle.
- Capture:
  - On every cycle with phi2_s = 1, en_n_s = 0 and rw_s = 0, load the capture register with {REG_s, DATA_s} and set write_seen = 1.
  - A later qualifying cycle overwrites the capture, so the last sample of the phi2-high phase wins.
- Commit:
  - A fall is phi2_d = 1 with phi2_s = 0.
  - On a fall with write_seen = 1: push the capture register and clear write_seen.
  - On a fall with write_seen = 0: do nothing.
  - Read cycles (rw_s = 1) and deselected cycles never set write_seen.
- Latency: cmd_valid rises exactly SYNC_STAGES+1 CLK_FAST rising edges after the first edge that samples CLK_CPU low, provided the FIFO was empty.
- Bus timing requirement: CLK_CPU high and low phases must each last at least SYNC_STAGES+2 CLK_FAST cycles.
- FIFO organisation:
  - Show-ahead FIFO: cmd_reg/cmd_data always reflect mem[rd_ptr].
  - cmd_valid = (fifo_count != 0).
  - No fall-through: a push into an empty FIFO makes cmd_valid visible on the following cycle.
- Pop: occurs when cmd_valid & cmd_ready; rd_ptr increments. cmd_ready while empty is ignored.
- Push: writes mem[wr_ptr]; wr_ptr increments.
- Pointers are DEPTH_LOG2 bits wide and wrap modulo 2^DEPTH_LOG2.
- fifo_count update per cycle:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
- Full: fifo_count = 2^DEPTH_LOG2.
  - Push while full with a pop in the same cycle: push accepted, count stays full.
  - Push while full without a pop: command discarded, pointers and count unchanged, overflow set to 1.
- Overflow:
  - clr_overflow = 1 clears overflow on the next edge.
  - If an overflow event and clr_overflow occur in the same cycle, set wins.
- Reset mid-operation: a pending capture and all queued commands are lost. The first fall after reset release does not push, because phi2_d resets to 0 and write_seen resets to 0.

Test Plan:
- Single write: REG=3, DATA=0x41, EN=0, RW=0, phi2 high 6 cycles then low -> cmd_valid=1 exactly 3 edges after the low sample; cmd_reg=3, cmd_data=0x41, fifo_count=1. Pulse cmd_ready -> fifo_count=0, cmd_valid=0.
- Read/deselect ignored: phi2 cycles with RW=1 and EN=0, then RW=0 and EN=1 -> fifo_count stays 0, cmd_valid=0.
- Fill and overflow: with DEPTH_LOG2=4 and cmd_ready=0, send 17 writes with DATA=0x00..0x10 -> fifo_count=16, overflow=1. Draining yields DATA 0x00..0x0F in order; 0x10 is absent.
- Full with simultaneous pop: FIFO full, cmd_ready held 1 during the push cycle of the next write -> count stays 16, overflow stays 0, newest entry is last out.
- Overflow clear: assert clr_overflow in the same cycle as a dropped push -> overflow stays 1. Assert clr_overflow alone -> overflow=0 on the next edge.
- Reset mid-operation: assert RESET while phi2 is high during a write with 5 entries queued -> fifo_count=0, cmd_valid=0, overflow=0 immediately. After release, the falling phi2 edge produces no push.

Source files
------------

// File: rtl/cpu_bus_cmd_fifo.sv
// Purpose: samples the asynchronous 6502 bus in the CLK_FAST domain and queues completed CPU writes as {REG, DATA} commands.
// Latency: cmd_valid rises SYNC_STAGES+1 CLK_FAST edges after the first edge that samples CLK_CPU low (empty FIFO).
// Backpressure: consumer pops with cmd_valid/cmd_ready; a write arriving while full with no pop is dropped and flags sticky overflow.
//
// Ports:
//   CLK_FAST, RESET            system clock, asynchronous active-high reset
//   CLK_CPU, EN, RW, REG, DATA raw 6502 bus (phi2, select_n, read/write_n, register, data)
//   cmd_valid/cmd_ready        show-ahead head handshake, head fields cmd_reg/cmd_data
//   fifo_count                 number of stored commands (0 .. 2^DEPTH_LOG2)
//   overflow, clr_overflow     sticky drop flag and its clear (set wins over clear)

// Generic show-ahead FIFO. Head data is mem[rd_ptr] at all times; no fall-through,
// so a push into an empty FIFO becomes visible one cycle later.
// wr_rdy stays high when full if a pop happens in the same cycle.
module cmd_fifo #(
  parameter int WIDTH      = 11,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  CLK_FAST,
  input  logic                  RESET,
  input  logic                  wr_vld,
  input  logic [WIDTH-1:0]      wr_dat,
  output logic                  wr_rdy,
  output logic                  rd_vld,
  output logic [WIDTH-1:0]      rd_dat,
  input  logic                  rd_rdy,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = DEPTH;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  push;
  logic                  pop;

  assign rd_vld = (count != '0);
  assign rd_dat = mem[rd_ptr];
  assign pop    = rd_vld & rd_rdy;
  // A simultaneous pop frees the slot the push lands in.
  assign wr_rdy = (count != CNT_FULL) | pop;
  assign push   = wr_vld & wr_rdy;

  // Storage is not reset: contents are don't-care while rd_vld is low.
  always_ff @(posedge CLK_FAST) begin
    if (push) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  always_ff @(posedge CLK_FAST or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

module cpu_bus_cmd_fifo #(
  parameter int DEPTH_LOG2  = 4,
  parameter int SYNC_STAGES = 2   // must be >= 2
) (
  input  logic                  CLK_FAST,
  input  logic                  RESET,
  input  logic                  CLK_CPU,
  input  logic                  EN,
  input  logic                  RW,
  input  logic [2:0]            REG,
  input  logic [7:0]            DATA,
  output logic                  cmd_valid,
  output logic [2:0]            cmd_reg,
  output logic [7:0]            cmd_data,
  input  logic                  cmd_ready,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  overflow,
  input  logic                  clr_overflow
);

  // Synchronizer chains. REG/DATA go through the same depth as the controls so
  // that a qualifying control sample always pairs with the bus value of that moment.
  logic [SYNC_STAGES-1:0] phi2_sr;
  logic [SYNC_STAGES-1:0] en_n_sr;
  logic [SYNC_STAGES-1:0] rw_sr;
  logic [10:0]            bus_sr [SYNC_STAGES];

  logic        phi2_s;
  logic        en_n_s;
  logic        rw_s;
  logic [10:0] bus_s;
  logic        phi2_d;
  logic        write_seen;
  logic [10:0] capture;
  logic        fall;
  logic        wr_cycle;
  logic        push_vld;
  logic        push_rdy;
  logic [10:0] head;

  always_ff @(posedge CLK_FAST or posedge RESET) begin
    if (RESET) begin
      phi2_sr <= '0;
      en_n_sr <= '1;   // deselected
      rw_sr   <= '1;   // read
      for (int i = 0; i < SYNC_STAGES; i++) begin
        bus_sr[i] <= '0;
      end
    end else begin
      phi2_sr   <= {phi2_sr[SYNC_STAGES-2:0], CLK_CPU};
      en_n_sr   <= {en_n_sr[SYNC_STAGES-2:0], EN};
      rw_sr     <= {rw_sr[SYNC_STAGES-2:0], RW};
      bus_sr[0] <= {REG, DATA};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        bus_sr[i] <= bus_sr[i-1];
      end
    end
  end

  assign phi2_s = phi2_sr[SYNC_STAGES-1];
  assign en_n_s = en_n_sr[SYNC_STAGES-1];
  assign rw_s   = rw_sr[SYNC_STAGES-1];
  assign bus_s  = bus_sr[SYNC_STAGES-1];

  assign wr_cycle = phi2_s & ~en_n_s & ~rw_s;
  assign fall     = phi2_d & ~phi2_s;
  assign push_vld = fall & write_seen;

  // Capture keeps re-loading during the phi2-high phase so the last (settled)
  // sample wins; the push happens on the detected phi2 fall.
  always_ff @(posedge CLK_FAST or posedge RESET) begin
    if (RESET) begin
      phi2_d     <= 1'b0;
      write_seen <= 1'b0;
      capture    <= '0;
    end else begin
      phi2_d <= phi2_s;
      if (wr_cycle) begin
        capture    <= bus_s;
        write_seen <= 1'b1;
      end else if (fall) begin
        write_seen <= 1'b0;
      end
    end
  end

  cmd_fifo #(
    .WIDTH      (11),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .CLK_FAST (CLK_FAST),
    .RESET    (RESET),
    .wr_vld   (push_vld),
    .wr_dat   (capture),
    .wr_rdy   (push_rdy),
    .rd_vld   (cmd_valid),
    .rd_dat   (head),
    .rd_rdy   (cmd_ready),
    .count    (fifo_count)
  );

  assign cmd_reg  = head[10:8];
  assign cmd_data = head[7:0];

  // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge CLK_FAST or posedge RESET) begin
    if (RESET) begin
      overflow <= 1'b0;
    end else if (push_vld & ~push_rdy) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_bus_cmd_fifo.sv
module tb_cpu_bus_cmd_fifo;

  logic       CLK_FAST = 1'b0;
  logic       RESET;
  logic       CLK_CPU;
  logic       EN;
  logic       RW;
  logic [2:0] REG;
  logic [7:0] DATA;
  logic       cmd_valid;
  logic [2:0] cmd_reg;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic [4:0] fifo_count;
  logic       overflow;
  logic       clr_overflow;

  int n_pass  = 0;
  int n_total = 0;

  always #5 CLK_FAST = ~CLK_FAST;

  cpu_bus_cmd_fifo #(.DEPTH_LOG2(4), .SYNC_STAGES(2)) dut (
    .CLK_FAST     (CLK_FAST),
    .RESET        (RESET),
    .CLK_CPU      (CLK_CPU),
    .EN           (EN),
    .RW           (RW),
    .REG          (REG),
    .DATA         (DATA),
    .cmd_valid    (cmd_valid),
    .cmd_reg      (cmd_reg),
    .cmd_data     (cmd_data),
    .cmd_ready    (cmd_ready),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  // One phi2 cycle: 6 cycles high, about 5 low. cmd_ready / clr_overflow can be
  // driven high for exactly the cycle in which the commit push happens.
  task automatic bus_cycle(input logic en_n, input logic rw, input logic [2:0] r,
                           input logic [7:0] d, input bit rdy_push, input bit clr_push);
    @(negedge CLK_FAST);
    REG = r; DATA = d; EN = en_n; RW = rw; CLK_CPU = 1'b1;
    repeat (6) @(negedge CLK_FAST);
    CLK_CPU = 1'b0;
    @(posedge CLK_FAST);
    @(posedge CLK_FAST);
    #1;
    cmd_ready = rdy_push; clr_overflow = clr_push;
    @(posedge CLK_FAST);
    #1;
    cmd_ready = 1'b0; clr_overflow = 1'b0;
    repeat (3) @(negedge CLK_FAST);
    EN = 1'b1; RW = 1'b1;
  endtask

  task automatic pop_one();
    @(negedge CLK_FAST);
    cmd_ready = 1'b1;
    @(negedge CLK_FAST);
    cmd_ready = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; CLK_CPU = 1'b0; EN = 1'b1; RW = 1'b1; REG = '0; DATA = '0;
    cmd_ready = 1'b0; clr_overflow = 1'b0;
    repeat (3) @(negedge CLK_FAST);
    n_total++;
    if (fifo_count !== 5'd0 || cmd_valid !== 1'b0 || overflow !== 1'b0)
      $display("FAIL reset_hold: count=%0d valid=%b ovf=%b want 0/0/0", fifo_count, cmd_valid, overflow);
    else n_pass++;
    RESET = 1'b0;
    repeat (3) @(negedge CLK_FAST);
    n_total++;
    if (fifo_count !== 5'd0 || cmd_valid !== 1'b0 || overflow !== 1'b0)
      $display("FAIL reset_release: count=%0d valid=%b ovf=%b want 0/0/0", fifo_count, cmd_valid, overflow);
    else n_pass++;
  endtask

  task automatic test_single_write();
    logic [2:0] v;
    @(negedge CLK_FAST);
    REG = 3'd3; DATA = 8'h41; EN = 1'b0; RW = 1'b0; CLK_CPU = 1'b1;
    repeat (6) @(negedge CLK_FAST);
    CLK_CPU = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK_FAST);
      #1;
      v[i] = cmd_valid;
    end
    n_total++;
    if (v !== 3'b100)
      $display("FAIL single_latency: valid after edges 1..3 = %b%b%b want 001", v[0], v[1], v[2]);
    else n_pass++;
    n_total++;
    if (cmd_reg !== 3'd3 || cmd_data !== 8'h41 || fifo_count !== 5'd1)
      $display("FAIL single_head: reg=%0d data=%h count=%0d want 3/41/1", cmd_reg, cmd_data, fifo_count);
    else n_pass++;
    repeat (3) @(negedge CLK_FAST);
    EN = 1'b1; RW = 1'b1;
    pop_one();
    n_total++;
    if (fifo_count !== 5'd0 || cmd_valid !== 1'b0)
      $display("FAIL single_pop: count=%0d valid=%b want 0/0", fifo_count, cmd_valid);
    else n_pass++;
    // cmd_ready while empty must not disturb anything
    pop_one();
    n_total++;
    if (fifo_count !== 5'd0 || cmd_valid !== 1'b0)
      $display("FAIL empty_pop: count=%0d valid=%b want 0/0", fifo_count, cmd_valid);
    else n_pass++;
  endtask

  task automatic test_read_deselect();
    bus_cycle(1'b0, 1'b1, 3'd1, 8'h55, 1'b0, 1'b0);
    bus_cycle(1'b1, 1'b0, 3'd2, 8'hAA, 1'b0, 1'b0);
    bus_cycle(1'b1, 1'b1, 3'd4, 8'h77, 1'b0, 1'b0);
    repeat (4) @(negedge CLK_FAST);
    n_total++;
    if (fifo_count !== 5'd0 || cmd_valid !== 1'b0)
      $display("FAIL read_deselect: count=%0d valid=%b want 0/0", fifo_count, cmd_valid);
    else n_pass++;
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 17; i++) begin
      bus_cycle(1'b0, 1'b0, 3'(i), 8'(i), 1'b0, 1'b0);
    end
    n_total++;
    if (fifo_count !== 5'd16 || overflow !== 1'b1)
      $display("FAIL fill_overflow: count=%0d ovf=%b want 16/1", fifo_count, overflow);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      n_total++;
      if (cmd_valid !== 1'b1 || cmd_data !== 8'(i) || cmd_reg !== 3'(i))
        $display("FAIL drain_order[%0d]: valid=%b reg=%0d data=%h want 1/%0d/%h",
                 i, cmd_valid, cmd_reg, cmd_data, i % 8, i);
      else n_pass++;
      pop_one();
    end
    n_total++;
    if (fifo_count !== 5'd0 || cmd_valid !== 1'b0)
      $display("FAIL drain_empty: count=%0d valid=%b want 0/0 (0x10 must be absent)", fifo_count, cmd_valid);
    else n_pass++;
  endtask

  task automatic test_overflow_clear();
    @(negedge CLK_FAST);
    clr_overflow = 1'b1;
    @(negedge CLK_FAST);
    clr_overflow = 1'b0;
    n_total++;
    if (overflow !== 1'b0)
      $display("FAIL ovf_clear_first: ovf=%b want 0", overflow);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      bus_cycle(1'b0, 1'b0, 3'd5, 8'h40 + 8'(i), 1'b0, 1'b0);
    end
    n_total++;
    if (fifo_count !== 5'd16 || overflow !== 1'b0)
      $display("FAIL refill: count=%0d ovf=%b want 16/0", fifo_count, overflow);
    else n_pass++;
    bus_cycle(1'b0, 1'b0, 3'd5, 8'hEE, 1'b0, 1'b1);
    n_total++;
    if (overflow !== 1'b1 || fifo_count !== 5'd16)
      $display("FAIL ovf_set_wins: ovf=%b count=%0d want 1/16", overflow, fifo_count);
    else n_pass++;
    @(negedge CLK_FAST);
    clr_overflow = 1'b1;
    @(negedge CLK_FAST);
    clr_overflow = 1'b0;
    n_total++;
    if (overflow !== 1'b0)
      $display("FAIL ovf_clear_alone: ovf=%b want 0", overflow);
    else n_pass++;
    for (int i = 0; i < 16; i++) pop_one();
    n_total++;
    if (fifo_count !== 5'd0)
      $display("FAIL ovf_drain: count=%0d want 0", fifo_count);
    else n_pass++;
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 16; i++) begin
      bus_cycle(1'b0, 1'b0, 3'd6, 8'h20 + 8'(i), 1'b0, 1'b0);
    end
    bus_cycle(1'b0, 1'b0, 3'd7, 8'h30, 1'b1, 1'b0);
    n_total++;
    if (fifo_count !== 5'd16 || overflow !== 1'b0)
      $display("FAIL full_pop: count=%0d ovf=%b want 16/0", fifo_count, overflow);
    else n_pass++;
    for (int i = 0; i < 15; i++) begin
      n_total++;
      if (cmd_data !== 8'h21 + 8'(i))
        $display("FAIL full_pop_order[%0d]: data=%h want %h", i, cmd_data, 8'h21 + 8'(i));
      else n_pass++;
      pop_one();
    end
    n_total++;
    if (cmd_valid !== 1'b1 || cmd_reg !== 3'd7 || cmd_data !== 8'h30)
      $display("FAIL full_pop_last: valid=%b reg=%0d data=%h want 1/7/30", cmd_valid, cmd_reg, cmd_data);
    else n_pass++;
    pop_one();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      bus_cycle(1'b0, 1'b0, 3'd1, 8'h60 + 8'(i), 1'b0, 1'b0);
    end
    n_total++;
    if (fifo_count !== 5'd5)
      $display("FAIL pre_reset_count: count=%0d want 5", fifo_count);
    else n_pass++;
    @(negedge CLK_FAST);
    REG = 3'd2; DATA = 8'h99; EN = 1'b0; RW = 1'b0; CLK_CPU = 1'b1;
    repeat (4) @(negedge CLK_FAST);
    RESET = 1'b1;
    #1;
    n_total++;
    if (fifo_count !== 5'd0 || cmd_valid !== 1'b0 || overflow !== 1'b0)
      $display("FAIL reset_async: count=%0d valid=%b ovf=%b want 0/0/0", fifo_count, cmd_valid, overflow);
    else n_pass++;
    @(negedge CLK_FAST);
    EN = 1'b1; RW = 1'b1;
    repeat (2) @(negedge CLK_FAST);
    RESET = 1'b0;
    repeat (4) @(negedge CLK_FAST);
    CLK_CPU = 1'b0;
    repeat (8) @(negedge CLK_FAST);
    n_total++;
    if (fifo_count !== 5'd0 || cmd_valid !== 1'b0)
      $display("FAIL reset_no_push: count=%0d valid=%b want 0/0", fifo_count, cmd_valid);
    else n_pass++;
    bus_cycle(1'b0, 1'b0, 3'd4, 8'hC3, 1'b0, 1'b0);
    n_total++;
    if (fifo_count !== 5'd1 || cmd_reg !== 3'd4 || cmd_data !== 8'hC3)
      $display("FAIL post_reset_write: count=%0d reg=%0d data=%h want 1/4/c3", fifo_count, cmd_reg, cmd_data);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_deselect();
    test_fill_overflow();
    test_overflow_clear();
    test_full_pop();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
